// File: rtl/cpu_parameters.sv
// Core-wide sizing constants shared by the datapath blocks.
package cpu_parameters;
  localparam int xlen = 32;
endpackage

// File: rtl/interfaces_pkg.sv
// Bus structures passed between pipeline blocks, including the write-back
// bus and the indices of the write-back requesters.
package interfaces_pkg;
  import cpu_parameters::*;

  typedef struct packed {
    logic [xlen-1:0] data;
    logic [4:0]      adr;
  } wb_bus;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_CSR = 2;

  typedef struct packed {
    logic  valid;
    wb_bus bus;
  } wb_req_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational priority picker: first set request at or after `start`,
// wrapping modulo N. The one-hot and the encoded index are both returned.
module rr_pick #(
  parameter int N  = 3,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx
);
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(start) + i) % N]) begin
        found                     = 1'b1;
        gnt[(int'(start) + i) % N] = 1'b1;
        idx                       = SW'((int'(start) + i) % N);
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter with a one-entry output stage and a
// saturating contention counter. Define WB_ARB_RR_EN for round-robin grants.
module wb_arbiter
  import interfaces_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  wb_bus [NREQ-1:0]     req_bus,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  output wb_bus                out_bus,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     stall_cnt,
  input  logic                 stall_clr
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            stage_free;
  logic            grant;
  logic            contention;
  logic [NREQ-1:0] pick_gnt;
  logic [SW-1:0]   pick_idx;
  logic [SW-1:0]   start_idx;

`ifdef WB_ARB_RR_EN
  logic [SW-1:0] rr_ptr;
  assign start_idx = rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (grant)
      rr_ptr <= (pick_idx == SW'(NREQ - 1)) ? '0 : pick_idx + SW'(1);
  end
`else
  assign start_idx = '0;
`endif

  rr_pick #(.N(NREQ), .SW(SW)) u_pick (
    .req   (req_valid),
    .start (start_idx),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  // Grant depends only on valids and the output-stage state, never on req_bus.
  assign stage_free = !out_valid || out_ready;
  assign grant      = stage_free && !rst && (|req_valid);
  assign req_ready  = grant ? pick_gnt : '0;
  assign contention = |(req_valid & ~req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bus   <= '0;
    end else if (stage_free) begin
      if (grant) begin
        // Writes to x0 are accepted but dropped from the output stage.
        out_valid <= (req_bus[pick_idx].adr != 5'd0);
        if (req_bus[pick_idx].adr != 5'd0)
          out_bus <= req_bus[pick_idx];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (contention && !(&stall_cnt))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expectations follow the
// build selected by WB_ARB_RR_EN.
module tb_wb_arbiter;
  import interfaces_pkg::*;

  localparam int NREQ  = 3;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  wb_bus [NREQ-1:0]  req_bus;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  wb_bus             out_bus;
  logic              out_ready;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_clr;

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bus   (req_bus),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_bus   (out_bus),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int          exp_g;
  logic [31:0] exp_data;

  initial begin
    rst       = 1'b1;
    req_valid = 3'b111;
    out_ready = 1'b1;
    stall_clr = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_bus[i].data = 32'h100 + i;
      req_bus[i].adr  = 5'(i + 1);
    end
    tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_bus", out_bus, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    req_valid = '0;
    tick();
    rst = 1'b0;

    // Single ALU write
    req_valid       = 3'b001;
    req_bus[0].data = 32'hDEAD;
    req_bus[0].adr  = 5'd5;
    #1;
    check_eq("alu_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    check_eq("alu_out_valid", out_valid, 1);
    check_eq("alu_out_data", out_bus.data, 32'hDEAD);
    check_eq("alu_out_adr", out_bus.adr, 5);
    tick();
    check_eq("alu_drain", out_valid, 0);

    // All three requesters for six cycles, pointer fresh from reset
    do_reset();
    req_bus[0].data = 32'h100;
    req_bus[0].adr  = 5'd1;
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
`ifdef WB_ARB_RR_EN
      exp_g = c % 3;
`else
      exp_g = 0;
`endif
      #1;
      check_eq($sformatf("all_ready_%0d", c), req_ready, 3'(1 << exp_g));
      tick();
      check_eq($sformatf("all_data_%0d", c), out_bus.data, 32'h100 + exp_g);
    end
    check_eq("all_stall_cnt", stall_cnt, 6);
    exp_data = 32'h100 + exp_g;

    // Output stalled while L/S waits
    req_valid = 3'b010;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("hold_ready_%0d", c), req_ready, 0);
      tick();
      check_eq($sformatf("hold_data_%0d", c), out_bus.data, exp_data);
    end
    check_eq("hold_valid", out_valid, 1);
    check_eq("hold_stall_cnt", stall_cnt, 9);
    out_ready = 1'b1;
    #1;
    check_eq("release_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    check_eq("release_data", out_bus.data, 32'h101);
    check_eq("release_valid", out_valid, 1);

    // CSR write to x0 is acked and dropped
    req_valid       = 3'b100;
    req_bus[2].data = 32'h55;
    req_bus[2].adr  = 5'd0;
    #1;
    check_eq("x0_ready", req_ready, 3'b100);
    tick();
    req_valid = '0;
    check_eq("x0_out_valid", out_valid, 0);
    check_eq("x0_stall_cnt", stall_cnt, 9);

    // Counter saturation and clear priority
    req_valid       = 3'b001;
    req_bus[0].data = 32'h77;
    req_bus[0].adr  = 5'd3;
    tick();
    out_ready = 1'b0;
    stall_clr = 1'b1;
    tick();
    check_eq("clr_stall_cnt", stall_cnt, 0);
    stall_clr = 1'b0;
    repeat (255) tick();
    check_eq("sat_reach", stall_cnt, 8'hFF);
    repeat (5) tick();
    check_eq("sat_hold", stall_cnt, 8'hFF);
    stall_clr = 1'b1;
    tick();
    check_eq("sat_clr", stall_cnt, 0);
    stall_clr = 1'b0;
    tick();
    check_eq("post_clr_inc", stall_cnt, 1);

    // Asynchronous reset mid-stream
    check_eq("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_cnt", stall_cnt, 0);
    tick();
    rst       = 1'b0;
    req_valid = 3'b111;
    out_ready = 1'b1;
    req_bus[0].data = 32'h100;
    req_bus[0].adr  = 5'd1;
    req_bus[2].data = 32'h102;
    req_bus[2].adr  = 5'd3;
    #1;
    check_eq("after_rst_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    check_eq("after_rst_data", out_bus.data, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
